// File: rtl/score_bcd_accumulator.sv
// -----------------------------------------------------------------------------
// score_bcd_accumulator
//
// Tetris score keeper. Line-clear points are added directly in BCD, one digit
// per cycle, so the committed score can drive per-digit seven-segment decoders
// without any binary-to-BCD conversion. The award is the table constant for
// the number of lines, added (level+1) times.
//
// Optional feature macro: SCORE_HIGH_SCORE_EN (adds high_bcd / high_en).
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   clear      in   synchronous score clear (new game), highest priority
//   add_valid  in   score-add request
//   add_ready  out  idle, request can be accepted
//   lines      in   lines cleared (1..4 legal, others ignored)
//   level      in   level 0..9 (larger values clamped to 9)
//   score_bcd  out  committed score, digit 0 (LSD) in bits [3:0]
//   digit_en   out  leading-zero blanking, one bit per digit
//   saturated  out  score has pegged at all 9s
//   high_bcd   out  (SCORE_HIGH_SCORE_EN) highest committed score
//   high_en    out  (SCORE_HIGH_SCORE_EN) blanking for high_bcd
// -----------------------------------------------------------------------------
module score_bcd_accumulator #(
  parameter int DIGITS = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  add_valid,
  output logic                  add_ready,
  input  logic [2:0]            lines,
  input  logic [3:0]            level,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  saturated
`ifdef SCORE_HIGH_SCORE_EN
  ,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [DIGITS-1:0]     high_en
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Leading-zero blanking: bit i set when any digit at position >= i is nonzero.
  function automatic logic [DIGITS-1:0] lead_mask(input logic [W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              any;
    any = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any  = any | (v[i*4 +: 4] != 4'd0);
      m[i] = any;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  // BCD constant awarded per pass for a given number of cleared lines.
  function automatic logic [W-1:0] points_const(input logic [2:0] n);
    logic [W-1:0] r;
    r = '0;
    case (n)
      3'd1:    r[15:0] = 16'h0040;
      3'd2:    r[15:0] = 16'h0100;
      3'd3:    r[15:0] = 16'h0300;
      3'd4:    r[15:0] = 16'h1200;
      default: r[15:0] = 16'h0000;
    endcase
    return r;
  endfunction

`ifdef SCORE_HIGH_SCORE_EN
  // Digit-wise BCD magnitude compare, most significant digit decides first.
  function automatic logic bcd_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic done;
    logic gt;
    done = 1'b0;
    gt   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        done = 1'b1;
        gt   = (a[i*4 +: 4] > b[i*4 +: 4]);
      end
    end
    return gt;
  endfunction

  logic [W-1:0]      high_q, high_d;
  logic [DIGITS-1:0] high_en_q, high_en_d;
`endif

  state_t            state_q, state_d;
  logic [W-1:0]      work_q, work_d;
  logic [W-1:0]      const_q, const_d;
  logic [3:0]        pass_q, pass_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      score_q, score_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              sat_q, sat_d;

  logic              lines_legal_s;
  logic [3:0]        work_dig_s;
  logic [3:0]        const_dig_s;
  logic [4:0]        sum_s;
  logic              over_s;

  assign lines_legal_s = (lines >= 3'd1) && (lines <= 3'd4);

  // Single-digit BCD adder on the digit currently selected by idx.
  always_comb begin
    work_dig_s  = work_q[int'(idx_q)*4 +: 4];
    const_dig_s = const_q[int'(idx_q)*4 +: 4];
    sum_s       = {1'b0, work_dig_s} + {1'b0, const_dig_s} + {4'd0, carry_q};
    over_s      = (sum_s > 5'd9);
  end

  // Next-state and datapath control for IDLE / ADD / COMMIT.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    const_d = const_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    score_d = score_q;
    en_d    = en_q;
    sat_d   = sat_q;
`ifdef SCORE_HIGH_SCORE_EN
    high_d    = high_q;
    high_en_d = high_en_q;
`endif
    if (clear) begin
      // New game: abort anything in flight and drop a coincident request.
      state_d = S_IDLE;
      work_d  = '0;
      idx_d   = '0;
      carry_d = 1'b0;
      pass_d  = 4'd0;
      score_d = '0;
      en_d    = {{(DIGITS-1){1'b0}}, 1'b1};
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (add_valid && lines_legal_s) begin
            work_d  = score_q;
            const_d = points_const(lines);
            pass_d  = (level > 4'd9) ? 4'd9 : level;
            idx_d   = '0;
            carry_d = 1'b0;
            // Once pegged, requests commit the unchanged score straight away.
            state_d = sat_q ? S_COMMIT : S_ADD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADD: begin
          work_d[int'(idx_q)*4 +: 4] = over_s ? (sum_s[3:0] - 4'd10) : sum_s[3:0];
          if (idx_q == LAST_IDX) begin
            carry_d = 1'b0;
            idx_d   = '0;
            if (over_s) begin
              work_d  = {DIGITS{4'h9}};
              sat_d   = 1'b1;
              state_d = S_COMMIT;
            end else if (pass_q == 4'd0) begin
              state_d = S_COMMIT;
            end else begin
              pass_d = pass_q - 4'd1;
            end
          end else begin
            carry_d = over_s;
            idx_d   = idx_q + IW'(1);
          end
        end
        S_COMMIT: begin
          score_d = work_q;
          en_d    = lead_mask(work_q);
`ifdef SCORE_HIGH_SCORE_EN
          if (bcd_gt(work_q, high_q)) begin
            high_d    = work_q;
            high_en_d = lead_mask(work_q);
          end else begin
            high_d    = high_q;
          end
`endif
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; high score survives clear, not resetn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      const_q <= '0;
      pass_q  <= 4'd0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      score_q <= '0;
      en_q    <= {{(DIGITS-1){1'b0}}, 1'b1};
      sat_q   <= 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
      high_q    <= '0;
      high_en_q <= {{(DIGITS-1){1'b0}}, 1'b1};
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      const_q <= const_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      score_q <= score_d;
      en_q    <= en_d;
      sat_q   <= sat_d;
`ifdef SCORE_HIGH_SCORE_EN
      high_q    <= high_d;
      high_en_q <= high_en_d;
`endif
    end
  end

  assign add_ready = (state_q == S_IDLE);
  assign score_bcd = score_q;
  assign digit_en  = en_q;
  assign saturated = sat_q;
`ifdef SCORE_HIGH_SCORE_EN
  assign high_bcd  = high_q;
  assign high_en   = high_en_q;
`endif

endmodule

// File: tb/tb_score_bcd_accumulator.sv
module tb_score_bcd_accumulator;

  logic        clock = 1'b0;
  logic        resetn;
  logic        clear;
  logic        add_valid;
  logic        add_ready;
  logic [2:0]  lines;
  logic [3:0]  level;
  logic [23:0] score_bcd;
  logic [5:0]  digit_en;
  logic        saturated;
`ifdef SCORE_HIGH_SCORE_EN
  logic [23:0] high_bcd;
  logic [5:0]  high_en;
`endif

  always #5 clock = ~clock;

  score_bcd_accumulator #(.DIGITS(6)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (clear),
    .add_valid (add_valid),
    .add_ready (add_ready),
    .lines     (lines),
    .level     (level),
    .score_bcd (score_bcd),
    .digit_en  (digit_en),
    .saturated (saturated)
`ifdef SCORE_HIGH_SCORE_EN
    ,
    .high_bcd  (high_bcd),
    .high_en   (high_en)
`endif
  );

  typedef struct {
    logic [23:0] score;
    logic [5:0]  en;
    logic        sat;
    int          lat;   // expected busy cycles, -1 when not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_score = 0;
  bit   model_sat = 1'b0;
  int   model_high = 0;
  bit   mon_en = 1'b0;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] exp_en(input int v);
    logic [5:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[i] = (i == 0) || (v >= p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: a completed operation is seen as add_ready rising.
  logic        prev_rdy = 1'b1;
  int          busy = 0;
  logic [23:0] hold = 24'd0;
  bit          partial_bad = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!mon_en) begin
      prev_rdy = 1'b1; busy = 0; hold = score_bcd; partial_bad = 1'b0;
    end else if (!add_ready) begin
      busy++;
      if (score_bcd !== hold) partial_bad = 1'b1;
      prev_rdy = 1'b0;
    end else begin
      if (!prev_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_completion actual_score=%h", score_bcd);
        end else begin
          e = exp_q.pop_front();
          check("score_bcd", 32'(score_bcd), 32'(e.score));
          check("digit_en", 32'(digit_en), 32'(e.en));
          check("saturated", 32'(saturated), 32'(e.sat));
          if (e.lat >= 0) check("latency", 32'(busy), 32'(e.lat));
          check("no_partial_sum", 32'(partial_bad), 32'd0);
        end
      end
      prev_rdy = 1'b1; busy = 0; hold = score_bcd; partial_bad = 1'b0;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !add_ready) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0 || !add_ready) begin
      checks++; failures++;
      $display("FAIL timeout actual_pending=%0d required_pending=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic req(input int ln, input int lv);
    exp_t e;
    int pts, n, k;
    case (ln)
      1: pts = 40;
      2: pts = 100;
      3: pts = 300;
      default: pts = 1200;
    endcase
    n = ((lv > 9) ? 9 : lv) + 1;
    if (model_sat) begin
      e.lat = 1;
    end else begin
      k = 0;
      for (int j = 1; j <= n; j++)
        if (k == 0 && model_score + j * pts > 999999) k = j;
      if (k != 0) begin
        model_score = 999999; model_sat = 1'b1; e.lat = k * 6 + 1;
      end else begin
        model_score = model_score + n * pts; e.lat = n * 6 + 1;
      end
    end
    if (model_score > model_high) model_high = model_score;
    e.score = to_bcd(model_score); e.en = exp_en(model_score); e.sat = model_sat;
    exp_q.push_back(e);
    @(negedge clock);
    add_valid = 1'b1; lines = 3'(ln); level = 4'(lv);
    @(negedge clock);
    add_valid = 1'b0;
    wait_idle(2000);
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    model_score = 0; model_sat = 1'b0;
  endtask

  initial begin
    exp_t e;
    resetn = 1'b0; clear = 1'b0; add_valid = 1'b0; lines = 3'd0; level = 4'd0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("reset_score", 32'(score_bcd), 32'h0);
    check("reset_digit_en", 32'(digit_en), 32'h01);
    check("reset_add_ready", 32'(add_ready), 32'd1);
    check("reset_saturated", 32'(saturated), 32'd0);
    mon_en = 1'b1;

    req(1, 0);   // 000040, 7 busy cycles
    req(4, 2);   // 003640, 19 busy cycles

    // Run up to saturation from zero.
    pulse_clear();
    check("clear_idle_score", 32'(score_bcd), 32'h0);
    for (int r = 0; r < 83; r++) req(4, 9);
    check("score_996000", 32'(score_bcd), 32'h996000);
    req(4, 9);   // overflows in the 4th pass -> 999999
    req(1, 0);   // saturated: immediate commit, unchanged
    pulse_clear();
    check("clear_saturated", 32'(saturated), 32'd0);
    check("clear_score", 32'(score_bcd), 32'h0);

    // Clear aborting an in-flight add.
    req(2, 0);   // 000100
    e.score = 24'h0; e.en = 6'b000001; e.sat = 1'b0; e.lat = -1;
    exp_q.push_back(e);
    @(negedge clock); add_valid = 1'b1; lines = 3'd3; level = 4'd0;
    @(negedge clock); add_valid = 1'b0;
    @(negedge clock);
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    model_score = 0; model_sat = 1'b0;
    check("abort_add_ready", 32'(add_ready), 32'd1);
    wait_idle(50);
    repeat (20) @(negedge clock);
    check("abort_final_score", 32'(score_bcd), 32'h0);

    // Clear and request in the same cycle: request dropped.
    req(1, 0);   // 000040
    @(negedge clock); clear = 1'b1; add_valid = 1'b1; lines = 3'd1; level = 4'd0;
    @(negedge clock); clear = 1'b0; add_valid = 1'b0;
    model_score = 0;
    check("drop_score", 32'(score_bcd), 32'h0);
    repeat (10) @(negedge clock);
    check("drop_score_later", 32'(score_bcd), 32'h0);
    check("drop_add_ready", 32'(add_ready), 32'd1);

    // Illegal line counts are consumed and ignored.
    req(1, 0);   // 000040
    for (int t = 0; t < 2; t++) begin
      @(negedge clock); add_valid = 1'b1; lines = (t == 0) ? 3'd0 : 3'd5; level = 4'd3;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        check("illegal_add_ready", 32'(add_ready), 32'd1);
        check("illegal_score", 32'(score_bcd), 32'h40);
      end
      add_valid = 1'b0;
    end
    req(3, 12);  // level clamped to 9: 40 + 3000 = 003040

`ifdef SCORE_HIGH_SCORE_EN
    check("high_across_clear", 32'(high_bcd), 32'(to_bcd(model_high)));
    check("high_en", 32'(high_en), 32'(exp_en(model_high)));
`endif

    // Reset asserted mid-operation.
    mon_en = 1'b0;
    @(negedge clock); add_valid = 1'b1; lines = 3'd4; level = 4'd1;
    @(negedge clock); add_valid = 1'b0;
    @(negedge clock); resetn = 1'b0;
    #1;
    check("midreset_score", 32'(score_bcd), 32'h0);
    check("midreset_digit_en", 32'(digit_en), 32'h01);
    check("midreset_add_ready", 32'(add_ready), 32'd1);
    check("midreset_saturated", 32'(saturated), 32'd0);
`ifdef SCORE_HIGH_SCORE_EN
    check("midreset_high", 32'(high_bcd), 32'h0);
`endif
    @(negedge clock); resetn = 1'b1;
    repeat (20) @(negedge clock);
    check("post_reset_score", 32'(score_bcd), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_bcd_accumulator.md
Name: score_bcd_accumulator

Overview:
- Tetris score keeper. Accumulates line-clear points directly in BCD and drives one 4-bit digit plus one blank-enable per seven-segment decoder.
- Sits upstream of the per-digit hex decoders: each digit's nibble goes to the decoder's `c` input, and its enable bit goes to the decoder's `enable` input.
- Performs the addition digit-serially in a small FSM, so no binary-to-BCD converter is needed.

Parameters:
- DIGITS, 6, number of BCD digits held and displayed (at least 4, because 1200 needs 4 digits).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous score clear (new game).
- add_valid  in  1  score-add request.
- add_ready  out  1  block is idle and can accept a request.
- lines  in  3  lines cleared by the piece; only 1 to 4 are legal.
- level  in  4  current level, 0 to 9; values above 9 are clamped to 9.
- score_bcd  out  4*DIGITS  committed score; digit 0 is the LSD in bits [3:0].
- digit_en  out  DIGITS  leading-zero blanking, one bit per digit, wired to decoder `enable`.
- saturated  out  1  score has pegged at all 9s.

Behaviour:
- Reset values (resetn=0, asynchronous): score_bcd=0, working register=0, digit_en = 1 in bit 0 only, add_ready=1, saturated=0, state IDLE.
- Points table (BCD constant per request): lines=1 → 40, 2 → 100, 3 → 300, 4 → 1200. The total awarded is the table value × (level+1), implemented as (level+1) repeated additions.
- States:
  - IDLE: add_ready=1. A handshake (add_valid & add_ready) with lines in 1..4 latches the table constant, sets pass_cnt = min(level,9), digit index = 0, copies score_bcd into the working register, and moves to ADD.
  - IDLE, illegal request: lines=0 or lines>4 is consumed and ignored. State stays IDLE, add_ready stays 1, nothing changes.
  - ADD: add_ready=0. Each cycle processes one digit: s = work[idx] + const[idx] + carry. If s>9, write s-10 and set carry=1; otherwise write s and set carry=0. Then idx increments.
  - ADD, end of pass (idx=DIGITS-1): carry is cleared and then:
    - carry out of the top digit → all working digits are set to 9, saturated=1, go to COMMIT;
    - else if pass_cnt=0 → COMMIT;
    - else pass_cnt decrements and idx returns to 0.
  - COMMIT: score_bcd ← working register, then IDLE. This takes one cycle; add_ready rises in the cycle after.
- Latency from the accepting edge to the score_bcd update: (level+1)*DIGITS + 1 cycles. score_bcd never shows partial sums.
- Once saturated=1, later requests are accepted and immediately committed unchanged. saturated clears only on clear or reset.
- digit_en[i] = 1 if any digit at position ≥ i is nonzero; digit_en[0] is always 1. It is registered and updated in the same cycle as score_bcd.
- clear, when high at an edge, takes priority over everything:
  - score, working register and saturated go to 0; digit_en goes to 1 in bit 0 only;
  - any add in progress is aborted, the state goes to IDLE and add_ready=1 on the next cycle;
  - an add_valid in the same cycle is dropped.
- Reset asserted mid-operation: identical to the reset values above; the in-flight request is lost.

Optional Feature:
- Macro: SCORE_HIGH_SCORE_EN.
- When defined:
  - adds output high_bcd [4*DIGITS-1:0] and register high_en [DIGITS-1:0] with the same blanking rule as digit_en;
  - on each COMMIT, if the new score is greater than high_bcd (digit-wise BCD compare, MSD first), high_bcd ← new score in the same edge;
  - high_bcd resets to 0 on resetn only; clear does not affect it.
- When not defined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then idle 5 cycles → score_bcd=000000, digit_en=000001, add_ready=1, saturated=0.
- lines=1, level=0, one handshake → add_ready low for 7 cycles; score_bcd=000040 exactly 7 cycles after the accepting edge; digit_en=000011.
- From 000040: lines=4, level=2 → score 003640 after 19 cycles; digit_en=001111; no intermediate value is visible on score_bcd.
- 83 requests of lines=4, level=9 (12000 each) → 996000. An 84th request → score_bcd=999999, saturated=1. A further lines=1 request → still 999999.
- clear pulsed 3 cycles after accepting a lines=3 request from 000100 → score_bcd=000000, add_ready=1 next cycle, final score stays 000000. Repeat with clear and add_valid in the same cycle → request dropped.
- lines=0 and lines=5 with add_valid held for 4 cycles → score unchanged, add_ready stays 1. With SCORE_HIGH_SCORE_EN defined: high_bcd tracks the max across a clear, and resets only on resetn.
